fifo_mem: RTL
=============

# fifo_mem

Parametrised synchronous FIFO built on a single-clock RAM array, generalising the team's simple addressed memory into a self-addressing buffer with occupancy tracking. It sits between the operand producers and the dot-product FSM, absorbing bursts so the FSM can pop operands at its own pace. Internal write/read pointers replace external addresses. Full, empty, threshold and error flags give the FSM everything it needs to throttle.

## Interface
- DATA_WIDTH, 8, width of each stored word
- ADDR_WIDTH, 4, pointer width; depth DEPTH = 2**ADDR_WIDTH (16)
- AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of pointers/count
- clear_err  in  1  synchronous clear of sticky error flags
- write_en  in  1  push request
- data_in  in  DATA_WIDTH  push data
- read_en  in  1  pop request
- data_out  out  DATA_WIDTH  registered pop data
- data_valid  out  1  one-cycle pulse: data_out updated this cycle
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- full / empty  out  1  count == DEPTH / count == 0
- almost_full / almost_empty  out  1  threshold flags
- overflow / underflow  out  1  sticky error flags

## Operation
- Write accepted iff write_en && !full: mem[wr_ptr] <= data_in, wr_ptr++.
- Read accepted iff read_en && !empty: data_out <= mem[rd_ptr], rd_ptr++, data_valid <= 1; otherwise data_valid <= 0 and data_out holds.
- full blocks writes even if a read is accepted the same cycle. empty blocks reads even if a write is accepted the same cycle; there is no fall-through bypass.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- count: +1 on write-only, -1 on read-only, else unchanged. It never exceeds DEPTH or goes below 0.
- Pointers are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally.
- Rejected write (write_en && full) sets overflow. Rejected read (read_en && empty) sets underflow.
- Error flags stay set until clear_err or reset. If clear_err coincides with a new error, the flag stays set (set wins).
- flush has priority over write_en/read_en in the same cycle:
  - wr_ptr, rd_ptr, count <= 0; data_valid <= 0.
  - data_out and memory contents hold; error flags unaffected.
- All flags are decoded combinationally from the count register only.
- Memory array is not reset; only control state is.

## Timing
- Asynchronous reset while rst_n = 0:
  - wr_ptr = rd_ptr = count = 0
  - data_out = 0, data_valid = 0
  - empty = 1, full = 0
  - almost_empty = 1 (AE_LEVEL >= 0), almost_full = 0
  - overflow = underflow = 0
- Reset deassertion is synchronous to clk from the bench side. The first op may occur on the first rising edge after release.
- Reset asserted mid-burst aborts immediately; any in-flight read does not complete.
- Read latency 1: read_en sampled at edge N gives data_out/data_valid valid after edge N, for one cycle.
- Flags and count reflect ops accepted at edge N immediately after edge N. Requesters sample them before edge N+1.
- Write to read turnaround: a word written at edge N is readable by read_en sampled at edge N+1.
- Sustained throughput: one push and one pop per cycle.

## Test plan
- Reset then basic order: push 0x11, 0x22, 0x33, then pop 3 -> data_out 0x11, 0x22, 0x33 on consecutive cycles with data_valid high. Count goes 3->0, then empty = 1.
- Fill and overflow:
  - push 16 words 0x00..0x0F -> full = 1, almost_full set after the 12th push, count = 16.
  - 17th push 0xFF -> overflow = 1, count stays 16.
  - Pop all -> 0x00..0x0F in order, 0xFF never appears.
- Underflow and clear:
  - On empty, read_en -> underflow = 1, data_valid = 0, data_out holds its last value.
  - clear_err -> underflow = 0 next cycle.
- Wrap-around with simultaneous ops:
  - Push 10, pop 10, then push 10 more (pointers cross 15->0).
  - Hold write_en and read_en high for 20 cycles with count = 5 -> count stays 5 and the data sequence is preserved.
- Flush and reset mid-operation:
  - With count = 7, assert flush together with write_en -> count = 0, empty = 1, write dropped.
  - Next push 0xA5 and pop -> 0xA5.
  - Assert rst_n = 0 asynchronously mid-pop -> all outputs at reset values without waiting for a clock edge.
- Threshold edges:
  - count 2 -> almost_empty = 1; count 3 -> almost_empty = 0.
  - count 11 -> almost_full = 0; count 12 -> almost_full = 1.

Source files
------------

// File: rtl/fifo_mem.sv
// Single-clock FIFO over a RAM array with self-managed pointers, occupancy count,
// threshold flags and sticky overflow/underflow flags.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  clear_err,
  input  logic                  write_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH-1:0] wr_ptr_nxt_s;
  logic [ADDR_WIDTH-1:0] rd_ptr_nxt_s;
  logic [CNT_W-1:0]      count_r;
  logic [CNT_W-1:0]      count_nxt_s;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  data_valid_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  wr_acc_s;
  logic                  rd_acc_s;
  logic                  ovf_set_s;
  logic                  udf_set_s;

  // Flags decode from the count register alone so they never depend on same-cycle requests.
  always_comb begin
    full_s       = (count_r == CNT_W'(DEPTH));
    empty_s      = (count_r == {CNT_W{1'b0}});
    almost_full  = (count_r >= CNT_W'(AF_LEVEL));
    almost_empty = (count_r <= CNT_W'(AE_LEVEL));
  end

  // Accept/reject decisions; flush masks all requests, including error detection.
  always_comb begin
    wr_acc_s  = 1'b0;
    rd_acc_s  = 1'b0;
    ovf_set_s = 1'b0;
    udf_set_s = 1'b0;
    if (flush) begin
      wr_acc_s  = 1'b0;
      rd_acc_s  = 1'b0;
      ovf_set_s = 1'b0;
      udf_set_s = 1'b0;
    end else begin
      wr_acc_s  = write_en && !full_s;
      rd_acc_s  = read_en && !empty_s;
      ovf_set_s = write_en && full_s;
      udf_set_s = read_en && empty_s;
    end
  end

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (flush) begin
      wr_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
      rd_ptr_nxt_s = {ADDR_WIDTH{1'b0}};
      count_nxt_s  = {CNT_W{1'b0}};
    end else begin
      if (wr_acc_s) begin
        wr_ptr_nxt_s = wr_ptr_r + ADDR_WIDTH'(1'b1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (rd_acc_s) begin
        rd_ptr_nxt_s = rd_ptr_r + ADDR_WIDTH'(1'b1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
        2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r <= {ADDR_WIDTH{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
    end
  end

  // Storage array; intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // Registered read port; data_out holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r   <= {DATA_WIDTH{1'b0}};
      data_valid_r <= 1'b0;
    end else if (rd_acc_s) begin
      data_out_r   <= mem_r[rd_ptr_r];
      data_valid_r <= 1'b1;
    end else begin
      data_valid_r <= 1'b0;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= ovf_set_s || (overflow_r && !clear_err);
      underflow_r <= udf_set_s || (underflow_r && !clear_err);
    end
  end

  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign count      = count_r;
  assign full       = full_s;
  assign empty      = empty_s;
  assign overflow   = overflow_r;
  assign underflow  = underflow_r;

endmodule
